// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions (state encoding, baud divisor helper,
//             frame length) used by the transmitter and the receiver.
//  Options  : UART_TX_PARITY_EN adds the even-parity state and bit.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

   // Line-side state encoding, shared with the receiver
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Bits per frame with a single stop bit: start + data + parity + stop
   localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

   // Clocks per bit, rounded to nearest
   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO, power-of-two depth, show-ahead read port.
//             Push is ignored when full, pop is ignored when empty.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int C_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [C_AW-1:0]  r_wr_ptr;
   logic [C_AW-1:0]  r_rd_ptr;
   logic [C_AW:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == (C_AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign pop_data  = r_mem[r_rd_ptr];
   assign count     = r_count;

   // Storage array; no reset needed, validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (C_AW+1)'(1);
            2'b01:   r_count <= r_count - (C_AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Buffered UART transmitter. Bytes enter a small FIFO over a
//             valid/ready handshake and leave as 8N1 frames on serial_txd.
//  Options  : define UART_TX_PARITY_EN for 8E1 framing (even parity bit).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 25000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          serial_txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int              DIV      = baud_div(CLK_HZ, BAUD);
   localparam int              C_BAUD_W = $clog2(DIV);
   localparam logic [C_BAUD_W-1:0] C_DIV_M1 = C_BAUD_W'(DIV - 1);
   localparam logic [2:0]      C_LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]      C_LAST_STOP = 3'(STOP_BITS - 1);

   uart_state_t         r_state, w_state_nxt;
   logic [C_BAUD_W-1:0] r_baud,  w_baud_nxt;
   logic [2:0]          r_bit,   w_bit_nxt;
   logic [7:0]          r_sh,    w_sh_nxt;
   logic                r_txd,   w_txd_nxt;
`ifdef UART_TX_PARITY_EN
   logic                r_par,   w_par_nxt;
`endif
   logic                w_tick;
   logic                w_push;
   logic                w_pop;
   logic [7:0]          w_head;
   logic                w_full;
   logic                w_empty;

   assign tx_ready   = !w_full;
   assign w_push     = tx_valid && tx_ready;
   assign w_tick     = (r_baud == '0);
   assign serial_txd = r_txd;
   assign busy       = (r_state != ST_IDLE) || !w_empty;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (tx_data),
      .pop       (w_pop),
      .pop_data  (w_head),
      .count     (fifo_count),
      .full      (w_full),
      .empty     (w_empty)
   );

   // State and datapath registers; reset forces the line idle at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_sh    <= w_sh_nxt;
         r_txd   <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

   // Next-state, bit sequencing and FIFO pop; a pop always starts a frame
   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_tick ? C_DIV_M1 : r_baud - C_BAUD_W'(1);
      w_bit_nxt   = r_bit;
      w_sh_nxt    = r_sh;
      w_txd_nxt   = r_txd;
      w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         ST_IDLE: begin
            w_baud_nxt = r_baud;
            w_txd_nxt  = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_sh_nxt    = w_head;
               w_txd_nxt   = 1'b0;
               w_baud_nxt  = C_DIV_M1;
               w_state_nxt = ST_START;
`ifdef UART_TX_PARITY_EN
               w_par_nxt   = ^w_head;
`endif
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state_nxt = ST_DATA;
               w_bit_nxt   = '0;
               w_txd_nxt   = r_sh[0];
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_bit == C_LAST_DATA) begin
                  w_bit_nxt   = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
                  w_txd_nxt   = r_par;
`else
                  w_state_nxt = ST_STOP;
                  w_txd_nxt   = 1'b1;
`endif
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
                  w_sh_nxt  = r_sh >> 1;
                  w_txd_nxt = r_sh[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_tick) begin
               w_state_nxt = ST_STOP;
               w_bit_nxt   = '0;
               w_txd_nxt   = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (w_tick) begin
               if (r_bit != C_LAST_STOP) begin
                  w_bit_nxt = r_bit + 3'd1;
               end else if (!w_empty) begin
                  // Chain straight into the next frame, no idle gap
                  w_pop       = 1'b1;
                  w_sh_nxt    = w_head;
                  w_txd_nxt   = 1'b0;
                  w_state_nxt = ST_START;
`ifdef UART_TX_PARITY_EN
                  w_par_nxt   = ^w_head;
`endif
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo with a line decoder that
//             compares received frames against a scoreboard queue.
//  Options  : UART_TX_PARITY_EN selects 8E1 expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

   localparam int DIV = 217;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       serial_txd;
   logic       busy;
   logic [2:0] fifo_count;

   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   bit         mon_en;
   bit         mon_busy = 1'b0;
   int         g_max;
   int         g_viol;
   int         push_cyc;

   uart_tx_fifo u_dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .serial_txd (serial_txd),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Occupancy tracking and ready-rule audit, called once per negedge
   task automatic sample();
      if (int'(fifo_count) > g_max) g_max = int'(fifo_count);
      if (fifo_count > 3'd4 || tx_ready !== (fifo_count != 3'd4)) g_viol++;
   endtask

   // Present a byte and hold it until accepted; starts and ends on a negedge
   task automatic push_byte(input logic [7:0] b, input bit track);
      int guard = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && guard < 20000) begin
         @(negedge clk);
         sample();
         guard++;
      end
      if (guard >= 20000) check("push_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      sample();
      push_cyc = cyc;
      if (track) exp_q.push_back(b);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      do begin
         @(negedge clk);
         sample();
         guard++;
      end while ((busy !== 1'b0 || mon_busy) && guard < 40000);
      if (guard >= 40000) check("idle_timeout", 0, 1);
   endtask

   // Line decoder: detects a start bit, samples mid-bit, checks the scoreboard
   initial begin
      logic [7:0] rx;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (mon_en && rst === 1'b0 && serial_txd === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            e = 8'h00;
            if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
            else e = exp_q.pop_front();
            repeat (DIV / 2) @(negedge clk);
            check("start_bit", serial_txd, 0);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               rx[i] = serial_txd;
            end
`ifdef UART_TX_PARITY_EN
            repeat (DIV) @(negedge clk);
            check("parity_bit", serial_txd, ^e);
`endif
            repeat (DIV) @(negedge clk);
            check("stop_bit", serial_txd, 1);
            check("rx_byte", rx, e);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin
      int bad;
      int t_low;
      int t_high;
      int guard;
      int k0;
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      mon_en   = 1'b0;
      g_max    = 0;
      g_viol   = 0;
      #1 rst = 1'b1;
      #5;
      check("rst_txd", serial_txd, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      // 1: idle line after reset
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (serial_txd !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      check("idle_1000", bad, 0);
      check("idle_ready", tx_ready, 1);

      // 2: single byte, latency and bit timing
      push_byte(8'hA9, 1'b1);
      guard = 0;
      while (serial_txd !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
      t_low = cyc;
      check("start_latency", t_low - push_cyc, 1);
      guard = 0;
      while (serial_txd !== 1'b1 && guard < 2 * DIV) begin @(negedge clk); guard++; end
      t_high = cyc;
      check("start_len", t_high - t_low, DIV);
      guard = 0;
      while (busy !== 1'b0 && guard < 4000) begin @(negedge clk); guard++; end
      check("busy_fall", cyc - t_low, FRAME * DIV);
      wait_idle();

      // 3: back-to-back frames
      starts.delete();
      g_max = 0;
      push_byte(8'hA9, 1'b1);
      push_byte(8'h01, 1'b1);
      push_byte(8'h8D, 1'b1);
      push_byte(8'h00, 1'b1);
      wait_idle();
      check("b2b_peak", g_max, 3);
      check("b2b_frames", starts.size(), 4);
      for (int i = 1; i < starts.size(); i++)
         check("b2b_gap", starts[i] - starts[i-1], FRAME * DIV);
      check("b2b_drain", exp_q.size(), 0);

      // 4: fill the FIFO with tx_valid held
      g_viol = 0;
      push_byte(8'h02, 1'b1);
      k0 = push_cyc;
      push_byte(8'h4C, 1'b1);
      push_byte(8'h00, 1'b1);
      push_byte(8'h06, 1'b1);
      push_byte(8'h55, 1'b1);
      check("full_count", fifo_count, 4);
      check("full_ready", tx_ready, 0);
      push_byte(8'hAA, 1'b1);
      check("full_accept_cyc", push_cyc - k0, 2 + FRAME * DIV);
      wait_idle();
      check("ready_rule", g_viol, 0);
      check("full_drain", exp_q.size(), 0);

      // 5: reset in the middle of a frame
      mon_en = 1'b0;
      push_byte(8'h55, 1'b0);
      k0 = push_cyc;
      push_byte(8'h33, 1'b0);
      guard = 0;
      while (cyc < k0 + 1 + 5 * DIV + DIV / 2 && guard < 3000) begin @(negedge clk); guard++; end
      check("mid_bit4", serial_txd, 1);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_txd", serial_txd, 1);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_count", fifo_count, 0);
      check("post_rst_ready", tx_ready, 1);
      mon_en = 1'b1;
      push_byte(8'h0F, 1'b1);
      wait_idle();
      check("post_rst_drain", exp_q.size(), 0);

`ifdef UART_TX_PARITY_EN
      // 6: parity frames
      starts.delete();
      push_byte(8'h07, 1'b1);
      push_byte(8'h03, 1'b1);
      wait_idle();
      check("par_frames", starts.size(), 2);
      if (starts.size() == 2) check("par_gap", starts[1] - starts[0], 11 * DIV);
      check("par_drain", exp_q.size(), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
